// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM-backed MEM-stage controller:
// FSM encoding, default base address and half-word select bits.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/wait_counter.sv
// Wait-state counter: counts enabled cycles from 0 and flags the last one
// (WAIT_CYCLES-1) on tc; clear has priority over enable.
module wait_counter #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data memory front end: splits each 32-bit load/store into two
// 16-bit asynchronous SRAM accesses and freezes the pipeline via ready.
module sram_mem_controller
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    state_t                 state;
    logic                   is_write;
    logic [15:0]            lo_reg;
    logic                   req;
    logic [31:0]            word_idx;
    logic [SRAM_ADDR_W-1:0] lo_addr;
    logic [SRAM_ADDR_W-1:0] hi_addr;
    logic                   cnt_en;
    logic                   cnt_clr;
    logic                   tc;

    assign req      = mem_r_en | mem_w_en;
    assign word_idx = (address - BASE_ADDR) >> 2;
    assign lo_addr  = SRAM_ADDR_W'({word_idx, HALF_LO});
    assign hi_addr  = SRAM_ADDR_W'({word_idx, HALF_HI});

    // The counter only runs inside a half-access; holding it cleared
    // elsewhere guarantees every half starts at zero.
    assign cnt_en  = (state == LO) || (state == HI);
    assign cnt_clr = !cnt_en || tc;

    wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clr),
        .en   (cnt_en),
        .tc   (tc)
    );

    assign ready = (state == IDLE) ? !req : (state == DONE);

    // SRAM pin values are loaded on the edge entering each state, so they
    // are already stable for the whole half-access window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            lo_reg      <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        is_write   <= mem_w_en;
                        sram_addr  <= lo_addr;
                        sram_we_n  <= !mem_w_en;
                        sram_dq_oe <= mem_w_en;
                        if (mem_w_en) begin
                            sram_dq_out <= write_data[15:0];
                        end
                        state <= LO;
                    end
                end
                LO: begin
                    if (tc) begin
                        if (!is_write) begin
                            lo_reg <= sram_dq_in;
                        end else begin
                            sram_dq_out <= write_data[31:16];
                        end
                        sram_addr <= hi_addr;
                        state     <= HI;
                    end
                end
                HI: begin
                    if (tc) begin
                        if (!is_write) begin
                            read_data <= {sram_dq_in, lo_reg};
                        end
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: a W=5 and a W=1 instance, each with an SRAM
// pin model, checked cycle by cycle against a word-level reference memory.
module tb_sram_mem_controller;

    localparam int unsigned AW    = 18;
    localparam int unsigned BASE  = 1024;
    localparam int unsigned NWORD = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          r_a, w_a, r_b, w_b;
    logic [31:0]   addr_a, wd_a, addr_b, wd_b;
    logic [31:0]   rd_a, rd_b;
    logic          ready_a, ready_b, oe_a, oe_b, we_a, we_b;
    logic [AW-1:0] sa_a, sa_b;
    logic [15:0]   dqo_a, dqo_b, dqi_a, dqi_b;

    logic [15:0] pin_a [0:(1<<AW)-1];
    logic [15:0] pin_b [0:(1<<AW)-1];
    logic [31:0] ref_a [0:NWORD-1];
    logic [31:0] ref_b [0:NWORD-1];
    logic [31:0] exp_rd_a, exp_rd_b;

    int total = 0;
    int bad   = 0;
    bit sel   = 1'b0;

    sram_mem_controller #(
        .BASE_ADDR(32'd1024), .WAIT_CYCLES(5), .SRAM_ADDR_W(AW)
    ) dut_a (
        .clk(clk), .rst(rst), .mem_r_en(r_a), .mem_w_en(w_a), .address(addr_a),
        .write_data(wd_a), .read_data(rd_a), .ready(ready_a), .sram_addr(sa_a),
        .sram_dq_out(dqo_a), .sram_dq_in(dqi_a), .sram_dq_oe(oe_a), .sram_we_n(we_a)
    );

    sram_mem_controller #(
        .BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_ADDR_W(AW)
    ) dut_b (
        .clk(clk), .rst(rst), .mem_r_en(r_b), .mem_w_en(w_b), .address(addr_b),
        .write_data(wd_b), .read_data(rd_b), .ready(ready_b), .sram_addr(sa_b),
        .sram_dq_out(dqo_b), .sram_dq_in(dqi_b), .sram_dq_oe(oe_b), .sram_we_n(we_b)
    );

    // Asynchronous SRAM devices: combinational read, write while we_n is low.
    assign dqi_a = pin_a[sa_a];
    assign dqi_b = pin_b[sa_b];
    always @(posedge clk) if (!we_a) pin_a[sa_a] <= dqo_a;
    always @(posedge clk) if (!we_b) pin_b[sa_b] <= dqo_b;

    logic [31:0]   o_rd;
    logic          o_ready, o_oe, o_we;
    logic [AW-1:0] o_sa;
    logic [15:0]   o_dqo;
    assign o_rd    = sel ? rd_b    : rd_a;
    assign o_ready = sel ? ready_b : ready_a;
    assign o_oe    = sel ? oe_b    : oe_a;
    assign o_we    = sel ? we_b    : we_a;
    assign o_sa    = sel ? sa_b    : sa_a;
    assign o_dqo   = sel ? dqo_b   : dqo_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            r_b = rd; w_b = wr; addr_b = a; wd_b = wd;
        end else begin
            r_a = rd; w_a = wr; addr_a = a; wd_a = wd;
        end
    endtask

    // One full access on the selected instance, called just after a rising edge.
    task automatic access(input bit rd, input bit wr, input int unsigned idx, input logic [31:0] wd);
        int unsigned w  = sel ? 1 : 5;
        bit          st = wr;
        logic [31:0] lo = 2 * idx;
        logic [31:0] hi = 2 * idx + 1;
        logic [31:0] exp_rd;
        exp_rd = sel ? exp_rd_b : exp_rd_a;
        if (st) begin
            if (sel) ref_b[idx] = wd; else ref_a[idx] = wd;
        end else if (rd) begin
            exp_rd = sel ? ref_b[idx] : ref_a[idx];
        end
        drive(rd, wr, BASE + idx * 4, wd);
        for (int k = 0; k <= 2 * int'(w) + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("req_ready", 32'(o_ready), 0);
            end else if (k <= 2 * int'(w)) begin
                chk("busy_ready", 32'(o_ready), 0);
                chk("sram_addr", 32'(o_sa), (k <= int'(w)) ? lo : hi);
                chk("we_n", 32'(o_we), st ? 0 : 1);
                chk("dq_oe", 32'(o_oe), st ? 1 : 0);
                if (st) chk("dq_out", 32'(o_dqo), 32'((k <= int'(w)) ? wd[15:0] : wd[31:16]));
            end else begin
                chk("done_ready", 32'(o_ready), 1);
                chk("done_we_n", 32'(o_we), 1);
                chk("done_oe", 32'(o_oe), 0);
                chk("read_data", o_rd, exp_rd);
            end
            @(posedge clk);
            #1;
        end
        if (sel) exp_rd_b = exp_rd; else exp_rd_a = exp_rd;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("idle_ready", 32'(o_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic random_accesses(input int n);
        for (int i = 0; i < n; i++) begin
            int unsigned op  = $urandom_range(0, 2);
            int unsigned idx = $urandom_range(0, 31);
            logic [31:0] wd  = $urandom;
            access(op != 1, op != 0, idx, wd);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NWORD); i++) begin
            ref_a[i] = $urandom;
            ref_b[i] = $urandom;
            pin_a[2*i]   = ref_a[i][15:0];
            pin_a[2*i+1] = ref_a[i][31:16];
            pin_b[2*i]   = ref_b[i][15:0];
            pin_b[2*i+1] = ref_b[i][31:16];
        end
        exp_rd_a = '0;
        exp_rd_b = '0;
        r_a = 0; w_a = 0; addr_a = 0; wd_a = 0;
        r_b = 0; w_b = 0; addr_b = 0; wd_b = 0;
        rst = 1'b1;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            chk("rst_ready", 32'(o_ready), 1);
            chk("rst_we_n", 32'(o_we), 1);
            chk("rst_oe", 32'(o_oe), 0);
            chk("rst_read_data", o_rd, 0);
            chk("rst_sram_addr", 32'(o_sa), 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed sequence on the W=5 instance.
        access(1'b0, 1'b1, 1, 32'hDEADBEEF);
        access(1'b1, 1'b0, 1, 32'd0);
        access(1'b1, 1'b1, 0, 32'h12345678);
        idle_cycle();
        access(1'b1, 1'b0, 0, 32'd0);
        access(1'b1, 1'b0, 2, 32'd0);
        idle_cycle();

        // Reset asserted during the high half of a store.
        drive(1'b0, 1'b1, BASE + 5 * 4, 32'hCAFEF00D);
        repeat (8) @(negedge clk);
        chk("pre_rst_addr", 32'(o_sa), 11);
        rst = 1'b1;
        #1;
        chk("mid_rst_we_n", 32'(o_we), 1);
        chk("mid_rst_oe", 32'(o_oe), 0);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        exp_rd_a = '0;
        exp_rd_b = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(o_ready), 1);
        chk("post_rst_we_n", 32'(o_we), 1);
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, 5, ref_a[5]);
        access(1'b1, 1'b0, 5, 32'd0);

        random_accesses(20);
        idle_cycle();

        // W=1 instance.
        sel = 1'b1;
        access(1'b0, 1'b1, 3, 32'hA5A55A5A);
        access(1'b1, 1'b0, 3, 32'd0);
        random_accesses(12);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
